fma_stream_checker: RTL and testbench

Synthesizable result checker for the pipelined FP32 FMA unit. It captures the expected IEEE-754 single-precision result alongside each vector issued to the FMA. Each expectation is delayed by the FMA latency and compared bitwise with the FMA output `d`. The block reports per-run check and error counts, plus the first failing vector, so regression runs (normal and special-value sets) can be self-checked on silicon or in gate-level simulation without a file-based scoreboard.

---
 rtl/fma_stream_checker.sv | 160 ++++++++++++++++
 tb/tb_fma_stream_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_stream_checker.sv
// Result checker for a pipelined FP32 FMA: each expected value rides a LAT-deep
// delay line beside its vector and is compared with the FMA output when it emerges.
module fma_stream_checker #(
    parameter int LAT    = 2,
    parameter int NAN_EQ = 0,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num,
    input  logic          in_valid,
    input  logic [31:0]   exp,
    input  logic [31:0]   dut_d,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          mismatch,
    output logic [CW-1:0] chk_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] first_idx,
    output logic [31:0]   first_got,
    output logic [31:0]   first_exp,
    output logic [1:0]    dbg_state
);

    // Handshake: a vector is taken on any rising edge where in_valid=1 in RUN and
    // start=0; there is no back-pressure, the FMA never stalls.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_num;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_chk;
    logic [CW-1:0] r_err;
    logic [CW-1:0] r_first_idx;
    logic [31:0]   r_first_got;
    logic [31:0]   r_first_exp;
    logic          r_mismatch;

    logic [LAT-1:0] r_dl_v;
    logic [31:0]    r_dl_exp [LAT];
    logic [CW-1:0]  r_dl_idx [LAT];

    logic          w_accept;
    logic [CW-1:0] w_issued_nxt;
    logic          w_cmp;
    logic [31:0]   w_out_exp;
    logic          w_exp_nan;
    logic          w_got_nan;
    logic          w_match;
    logic          w_fail;

    assign w_accept     = (r_state == S_RUN) && in_valid && !start;
    assign w_issued_nxt = r_issued + ONE;
    assign w_cmp        = r_dl_v[LAT-1] && !start;
    assign w_out_exp    = r_dl_exp[LAT-1];

    // Signed zeros and infinities are never NaN, so they always fall back to bitwise.
    assign w_exp_nan = (w_out_exp[30:23] == 8'hFF) && (w_out_exp[22:0] != 23'd0);
    assign w_got_nan = (dut_d[30:23] == 8'hFF) && (dut_d[22:0] != 23'd0);
    assign w_match   = (dut_d == w_out_exp) || ((NAN_EQ != 0) && w_exp_nan && w_got_nan);
    assign w_fail    = w_cmp && !w_match;

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = (num == '0) ? S_DRAIN : S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_accept && (w_issued_nxt == r_num)) w_state_nxt = S_DRAIN;
                S_DRAIN: if (!(|r_dl_v) && (r_chk == r_num)) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num       <= '0;
            r_issued    <= '0;
            r_chk       <= '0;
            r_err       <= '0;
            r_first_idx <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
            r_mismatch  <= 1'b0;
        end else if (start) begin
            r_num       <= num;
            r_issued    <= '0;
            r_chk       <= '0;
            r_err       <= '0;
            r_first_idx <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
            r_mismatch  <= 1'b0;
        end else begin
            r_mismatch <= w_fail;
            if (w_accept) r_issued <= w_issued_nxt;
            if (w_cmp) r_chk <= r_chk + ONE;
            if (w_fail) begin
                if (!(&r_err)) r_err <= r_err + ONE;
                // Saturation keeps r_err nonzero, so only the run's first error lands here.
                if (r_err == '0) begin
                    r_first_idx <= r_dl_idx[LAT-1];
                    r_first_got <= dut_d;
                    r_first_exp <= w_out_exp;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dl_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_dl_exp[i] <= '0;
                r_dl_idx[i] <= '0;
            end
        end else begin
            r_dl_v[0]   <= w_accept;
            r_dl_exp[0] <= exp;
            r_dl_idx[0] <= r_issued;
            for (int i = 1; i < LAT; i++) begin
                r_dl_v[i]   <= start ? 1'b0 : r_dl_v[i-1];
                r_dl_exp[i] <= r_dl_exp[i-1];
                r_dl_idx[i] <= r_dl_idx[i-1];
            end
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_err == '0);
    assign mismatch  = r_mismatch;
    assign chk_cnt   = r_chk;
    assign err_cnt   = r_err;
    assign first_idx = r_first_idx;
    assign first_got = r_first_got;
    assign first_exp = r_first_exp;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fma_stream_checker.sv
// Directed bench for fma_stream_checker: a strict instance and a NaN-tolerant
// instance share one stimulus stream fed by a two-stage stand-in for the FMA.
module tb_fma_stream_checker;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num = '0;
    logic          in_valid = 1'b0;
    logic [31:0]   exp_v = '0;
    logic [31:0]   dut_d = '0;

    logic          busy, done, pass, mismatch;
    logic [CW-1:0] chk_cnt, err_cnt, first_idx;
    logic [31:0]   first_got, first_exp;
    logic [1:0]    dbg_state;

    logic          busy_n, done_n, pass_n, mismatch_n;
    logic [CW-1:0] chk_cnt_n, err_cnt_n, first_idx_n;
    logic [31:0]   first_got_n, first_exp_n;
    logic [1:0]    dbg_state_n;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int s_edge = 0;
    int mm_a = 0;
    int mm_b = 0;
    logic [31:0] cur_got = '0;
    logic [31:0] pipe0 = '0;

    fma_stream_checker #(.LAT(2), .NAN_EQ(0), .CW(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num(num), .in_valid(in_valid),
        .exp(exp_v), .dut_d(dut_d), .busy(busy), .done(done), .pass(pass),
        .mismatch(mismatch), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
        .first_idx(first_idx), .first_got(first_got), .first_exp(first_exp),
        .dbg_state(dbg_state)
    );

    fma_stream_checker #(.LAT(2), .NAN_EQ(1), .CW(CW)) u_nan (
        .clk(clk), .rst(rst), .start(start), .num(num), .in_valid(in_valid),
        .exp(exp_v), .dut_d(dut_d), .busy(busy_n), .done(done_n), .pass(pass_n),
        .mismatch(mismatch_n), .chk_cnt(chk_cnt_n), .err_cnt(err_cnt_n),
        .first_idx(first_idx_n), .first_got(first_got_n), .first_exp(first_exp_n),
        .dbg_state(dbg_state_n)
    );

    always #5 clk = ~clk;

    // The FMA result for a vector sampled at edge t must sit on dut_d at edge t+2.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        dut_d = pipe0;
        pipe0 = cur_got;
        if (mismatch === 1'b1) mm_a++;
        if (mismatch_n === 1'b1) mm_b++;
    endtask

    task automatic cyc(input logic v, input logic [31:0] e, input logic [31:0] g);
        in_valid = v;
        exp_v = e;
        cur_got = g;
        tick();
        in_valid = 1'b0;
        cur_got = '0;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start = 1'b1;
        num = n;
        in_valid = 1'b0;
        cur_got = '0;
        tick();
        start = 1'b0;
        s_edge = cyc_n;
        mm_a = 0;
        mm_b = 0;
    endtask

    task automatic wait_done(output int rel);
        rel = -1;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) begin
                rel = cyc_n - s_edge;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({busy, done, pass, mismatch, chk_cnt, err_cnt, first_idx, first_got, first_exp, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b chk=%h err=%h st=%h required all zero",
                     busy, done, pass, chk_cnt, err_cnt, dbg_state);
        end
        rst = 1'b1;
        tick();
        total++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got st=%h busy=%b required st=0 busy=0", dbg_state, busy);
        end
    endtask

    task automatic test_basic();
        int rel;
        do_start(16'd4);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy got %b required 1", busy);
        end
        cyc(1'b1, 32'h3F800000, 32'h3F800000);
        cyc(1'b1, 32'h40000000, 32'h40000000);
        cyc(1'b1, 32'hC0490FDB, 32'hC0490FDB);
        cyc(1'b1, 32'h00000001, 32'h00000001);
        wait_done(rel);
        total++;
        if (rel !== 7) begin
            bad++;
            $display("FAIL basic_done_edge got %0d required 7", rel);
        end
        total++;
        if (pass !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_pass got pass=%b busy=%b required pass=1 busy=0", pass, busy);
        end
        total++;
        if (chk_cnt !== 16'd4 || err_cnt !== 16'd0 || mm_a !== 0) begin
            bad++;
            $display("FAIL basic_counts got chk=%0d err=%0d pulses=%0d required 4 0 0", chk_cnt, err_cnt, mm_a);
        end
    endtask

    task automatic test_mismatch();
        int rel;
        do_start(16'd5);
        cyc(1'b1, 32'h41200000, 32'h41200000);
        cyc(1'b1, 32'h3F000000, 32'h3F000000);
        cyc(1'b1, 32'h3F800000, 32'h3F800001);
        cyc(1'b1, 32'h7F800000, 32'h7F800000);
        cyc(1'b1, 32'h80000000, 32'h80000000);
        wait_done(rel);
        total++;
        if (rel !== 8) begin
            bad++;
            $display("FAIL mm_done_edge got %0d required 8", rel);
        end
        total++;
        if (mm_a !== 1 || err_cnt !== 16'd1 || chk_cnt !== 16'd5) begin
            bad++;
            $display("FAIL mm_counts got pulses=%0d err=%0d chk=%0d required 1 1 5", mm_a, err_cnt, chk_cnt);
        end
        total++;
        if (first_idx !== 16'd2 || first_got !== 32'h3F800001 || first_exp !== 32'h3F800000) begin
            bad++;
            $display("FAIL mm_first got idx=%0d got=%h exp=%h required 2 3f800001 3f800000",
                     first_idx, first_got, first_exp);
        end
        total++;
        if (pass !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL mm_pass got pass=%b done=%b required 0 1", pass, done);
        end
    endtask

    task automatic test_nan();
        int rel;
        do_start(16'd4);
        cyc(1'b1, 32'h7FC00000, 32'h7F800001);
        cyc(1'b1, 32'h00000000, 32'h80000000);
        cyc(1'b1, 32'h7F800000, 32'h7FC00000);
        cyc(1'b1, 32'h40490FDB, 32'h40490FDB);
        wait_done(rel);
        total++;
        if (rel !== 7 || done_n !== 1'b1) begin
            bad++;
            $display("FAIL nan_done got rel=%0d done_n=%b required 7 1", rel, done_n);
        end
        total++;
        if (err_cnt !== 16'd3 || first_idx !== 16'd0 || first_got !== 32'h7F800001) begin
            bad++;
            $display("FAIL nan_strict got err=%0d idx=%0d got=%h required 3 0 7f800001",
                     err_cnt, first_idx, first_got);
        end
        total++;
        if (err_cnt_n !== 16'd2 || mm_b !== 2 || chk_cnt_n !== 16'd4) begin
            bad++;
            $display("FAIL nan_eq_counts got err=%0d pulses=%0d chk=%0d required 2 2 4",
                     err_cnt_n, mm_b, chk_cnt_n);
        end
        total++;
        if (first_idx_n !== 16'd1 || first_got_n !== 32'h80000000 || first_exp_n !== 32'h0) begin
            bad++;
            $display("FAIL nan_eq_first got idx=%0d got=%h exp=%h required 1 80000000 00000000",
                     first_idx_n, first_got_n, first_exp_n);
        end
        total++;
        if (pass_n !== 1'b0) begin
            bad++;
            $display("FAIL nan_eq_pass got %b required 0", pass_n);
        end
    endtask

    task automatic test_gaps();
        int rel;
        do_start(16'd3);
        cyc(1'b1, 32'h3DCCCCCD, 32'h3DCCCCCD);
        cyc(1'b0, 32'hDEADBEEF, 32'h0);
        cyc(1'b0, 32'hDEADBEEF, 32'h0);
        total++;
        if (chk_cnt !== 16'd1) begin
            bad++;
            $display("FAIL gap_chk_first got %0d required 1", chk_cnt);
        end
        cyc(1'b1, 32'hBF800000, 32'hBF800000);
        cyc(1'b1, 32'h4B000000, 32'h4B000000);
        tick();
        total++;
        if (chk_cnt !== 16'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL gap_chk_second got chk=%0d busy=%b required 2 1", chk_cnt, busy);
        end
        tick();
        total++;
        if (chk_cnt !== 16'd3 || done !== 1'b0) begin
            bad++;
            $display("FAIL gap_chk_last got chk=%0d done=%b required 3 0", chk_cnt, done);
        end
        wait_done(rel);
        total++;
        if (rel !== 8 || pass !== 1'b1) begin
            bad++;
            $display("FAIL gap_done got rel=%0d pass=%b required 8 1", rel, pass);
        end
        cyc(1'b1, 32'h00000001, 32'h00000002);
        cyc(1'b1, 32'h00000001, 32'h00000002);
        cyc(1'b1, 32'h00000001, 32'h00000002);
        tick();
        tick();
        total++;
        if (chk_cnt !== 16'd3 || err_cnt !== 16'd0 || done !== 1'b1 || pass !== 1'b1 || mm_a !== 0) begin
            bad++;
            $display("FAIL gap_done_ignore got chk=%0d err=%0d done=%b pass=%b pulses=%0d required 3 0 1 1 0",
                     chk_cnt, err_cnt, done, pass, mm_a);
        end
    endtask

    task automatic test_restart();
        int rel;
        do_start(16'd6);
        cyc(1'b1, 32'h3F800000, 32'h3F800001);
        cyc(1'b1, 32'h40400000, 32'h40400004);
        cyc(1'b0, 32'h0, 32'h0);
        total++;
        if (err_cnt !== 16'd1 || mismatch !== 1'b1) begin
            bad++;
            $display("FAIL restart_pre got err=%0d mismatch=%b required 1 1", err_cnt, mismatch);
        end
        do_start(16'd2);
        total++;
        if (err_cnt !== 16'd0 || chk_cnt !== 16'd0 || mismatch !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear got err=%0d chk=%0d mismatch=%b busy=%b required 0 0 0 1",
                     err_cnt, chk_cnt, mismatch, busy);
        end
        total++;
        if (first_idx !== 16'd0 || first_got !== 32'h0 || first_exp !== 32'h0) begin
            bad++;
            $display("FAIL restart_first got idx=%0d got=%h exp=%h required all zero",
                     first_idx, first_got, first_exp);
        end
        cyc(1'b1, 32'h42280000, 32'h42280000);
        cyc(1'b1, 32'hC2C80000, 32'hC2C80000);
        wait_done(rel);
        total++;
        if (rel !== 5 || pass !== 1'b1 || chk_cnt !== 16'd2 || err_cnt !== 16'd0 || mm_a !== 0) begin
            bad++;
            $display("FAIL restart_run got rel=%0d pass=%b chk=%0d err=%0d pulses=%0d required 5 1 2 0 0",
                     rel, pass, chk_cnt, err_cnt, mm_a);
        end
    endtask

    task automatic test_reset_mid();
        do_start(16'd4);
        cyc(1'b1, 32'h00000001, 32'h00000002);
        cyc(1'b1, 32'h3F800000, 32'h3F800000);
        cyc(1'b1, 32'h3F800000, 32'h3F800000);
        cyc(1'b1, 32'h3F800000, 32'h3F800000);
        total++;
        if (err_cnt !== 16'd1 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL rstmid_pre got err=%0d st=%h required 1 2", err_cnt, dbg_state);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({busy, done, pass, mismatch, chk_cnt, err_cnt, first_idx, first_got, first_exp, dbg_state} !== '0) begin
            bad++;
            $display("FAIL rstmid_async got busy=%b err=%h got=%h exp=%h st=%h required all zero",
                     busy, err_cnt, first_got, first_exp, dbg_state);
        end
        tick();
        #3;
        rst = 1'b1;
        cyc(1'b1, 32'h00000005, 32'h00000006);
        cyc(1'b1, 32'h00000005, 32'h00000006);
        tick();
        tick();
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0 || chk_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rstmid_idle got done=%b busy=%b st=%h chk=%0d required 0 0 0 0",
                     done, busy, dbg_state, chk_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_nan();
        test_gaps();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
